// File: rtl/dmg_sio_pkg.sv
// Shared definitions for the serial I/O block: SC bit layout and FSM encoding.
package dmg_sio_pkg;

   localparam int unsigned SC_START_BIT   = 7;
   localparam int unsigned SC_CLKSEL_BIT  = 0;
   localparam logic [7:0]  SC_UNUSED_MASK = 8'h7E;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   // Build the SC read value; unused bits always read back as ones.
   function automatic logic [7:0] sc_pack(input logic start, input logic clksel);
      logic [7:0] v;
      v                = SC_UNUSED_MASK;
      v[SC_START_BIT]  = start;
      v[SC_CLKSEL_BIT] = clksel;
      return v;
   endfunction

endpackage

// File: rtl/dmg_sio_shifter.sv
// Serial data path: SB shift register, 3-bit bit counter and sout register.
// Strobes are mutually exclusive by construction in the controller.
module dmg_sio_shifter
   import dmg_sio_pkg::*;
(
   input  logic       clk_i,
   input  logic       res_i,
   input  logic       load_i,
   input  logic       clr_i,
   input  logic       fall_i,
   input  logic       rise_i,
   input  logic [7:0] wdata_i,
   input  logic       sin_i,
   output logic [7:0] sb_o,
   output logic [2:0] cnt_o,
   output logic       sout_o
);

   logic [7:0] sb_q, sb_d;
   logic [2:0] cnt_q, cnt_d;
   logic       sout_q, sout_d;

   // Next-state selection for the data path.
   always_comb begin
      sb_d   = sb_q;
      cnt_d  = cnt_q;
      sout_d = sout_q;
      if (load_i) begin
         sb_d = wdata_i;
      end else if (clr_i) begin
         cnt_d = 3'd0;
      end else if (fall_i) begin
         sout_d = sb_q[7];
      end else if (rise_i) begin
         sb_d  = {sb_q[6:0], sin_i};
         cnt_d = cnt_q + 3'd1;
      end else begin
         sb_d = sb_q;
      end
   end

   // Data path registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         sb_q   <= 8'h00;
         cnt_q  <= 3'd0;
         sout_q <= 1'b1;
      end else begin
         sb_q   <= sb_d;
         cnt_q  <= cnt_d;
         sout_q <= sout_d;
      end
   end

   assign sb_o   = sb_q;
   assign cnt_o  = cnt_q;
   assign sout_o = sout_q;

endmodule

// File: rtl/dmg_sio.sv
// Serial I/O controller: SB/SC registers, internal/external clocking, transfer FSM.
module dmg_sio
   import dmg_sio_pkg::*;
(
   input  logic       clk,
   input  logic       res,
   input  logic       tick,
   input  logic       sb_we,
   input  logic       sc_we,
   input  logic [7:0] wdata,
   output logic [7:0] sb_q,
   output logic [7:0] sc_q,
   input  logic       sck_in,
   input  logic       sin,
   output logic       sck_out,
   output logic       sck_oe,
   output logic       sout,
   output logic       irq
);

   state_e     state_q, state_d;
   logic       start_q, start_d;
   logic       clksel_q, clksel_d;
   logic       sck_out_q, sck_out_d;
   logic       irq_q, irq_d;
   logic       prev_sck_q;
   logic       ev_fall, ev_rise;
   logic       load, clr, fall, rise;
   logic [2:0] cnt;

   // Raw clock events; in internal mode the tick toggles sck_out, otherwise
   // edges of the synchronised external clock are detected.
   assign ev_fall = clksel_q ? (tick & sck_out_q)  : (prev_sck_q & ~sck_in);
   assign ev_rise = clksel_q ? (tick & ~sck_out_q) : (~prev_sck_q & sck_in);

   // FSM next state, register updates and data path strobes. Any register
   // write in a cycle wins over a simultaneous clock event.
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      clksel_d  = clksel_q;
      sck_out_d = sck_out_q;
      irq_d     = 1'b0;
      load      = 1'b0;
      clr       = 1'b0;
      fall      = 1'b0;
      rise      = 1'b0;
      case (state_q)
         IDLE: begin
            load = sb_we;
            if (sc_we) begin
               start_d  = wdata[SC_START_BIT];
               clksel_d = wdata[SC_CLKSEL_BIT];
               state_d  = wdata[SC_START_BIT] ? XFER : IDLE;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (sc_we) begin
               if (!wdata[SC_START_BIT]) begin
                  // Abort: SB keeps its partially shifted contents.
                  state_d   = IDLE;
                  start_d   = 1'b0;
                  clksel_d  = wdata[SC_CLKSEL_BIT];
                  sck_out_d = 1'b1;
                  clr       = 1'b1;
               end else begin
                  state_d = XFER;
               end
            end else if (sb_we) begin
               state_d = XFER;
            end else if (ev_fall) begin
               fall = 1'b1;
               if (clksel_q) begin
                  sck_out_d = 1'b0;
               end else begin
                  sck_out_d = sck_out_q;
               end
            end else if (ev_rise) begin
               rise      = 1'b1;
               sck_out_d = 1'b1;
               if (cnt == 3'd7) begin
                  state_d = IDLE;
                  start_d = 1'b0;
                  irq_d   = 1'b1;
               end else begin
                  state_d = XFER;
               end
            end else begin
               state_d = XFER;
            end
         end
         default: begin
            state_d   = IDLE;
            start_d   = 1'b0;
            sck_out_d = 1'b1;
         end
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         clksel_q   <= 1'b0;
         sck_out_q  <= 1'b1;
         irq_q      <= 1'b0;
         prev_sck_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         clksel_q   <= clksel_d;
         sck_out_q  <= sck_out_d;
         irq_q      <= irq_d;
         prev_sck_q <= sck_in;
      end
   end

   dmg_sio_shifter u_shifter (
      .clk_i   (clk),
      .res_i   (res),
      .load_i  (load),
      .clr_i   (clr),
      .fall_i  (fall),
      .rise_i  (rise),
      .wdata_i (wdata),
      .sin_i   (sin),
      .sb_o    (sb_q),
      .cnt_o   (cnt),
      .sout_o  (sout)
   );

   assign sc_q    = sc_pack(start_q, clksel_q);
   assign sck_out = sck_out_q;
   assign sck_oe  = clksel_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_dmg_sio.sv
// Directed self-checking bench for dmg_sio.
module tb_dmg_sio;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       tick = 1'b0;
   logic       sb_we = 1'b0;
   logic       sc_we = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] sb_q, sc_q;
   logic       sck_in = 1'b1;
   logic       sin = 1'b0;
   logic       sck_out, sck_oe, sout, irq;

   int n_checks = 0;
   int n_fail   = 0;
   int irq_cnt  = 0;

   dmg_sio dut (
      .clk     (clk),
      .res     (res),
      .tick    (tick),
      .sb_we   (sb_we),
      .sc_we   (sc_we),
      .wdata   (wdata),
      .sb_q    (sb_q),
      .sc_q    (sc_q),
      .sck_in  (sck_in),
      .sin     (sin),
      .sck_out (sck_out),
      .sck_oe  (sck_oe),
      .sout    (sout),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Count clock cycles during which irq is high.
   always @(posedge clk) begin
      if (irq === 1'b1) irq_cnt = irq_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_sb(input logic [7:0] v);
      sb_we = 1'b1; wdata = v;
      cyc(1);
      sb_we = 1'b0;
   endtask

   task automatic wr_sc(input logic [7:0] v);
      sc_we = 1'b1; wdata = v;
      cyc(1);
      sc_we = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         do_tick();
         cyc(1);
      end
   endtask

   initial begin
      int         base;
      logic [7:0] pat;
      logic [7:0] ebits;

      // Reset state
      cyc(2);
      res = 1'b0;
      cyc(1);
      check_eq("rst_sb", sb_q, 8'h00);
      check_eq("rst_sc", sc_q, 8'h7E);
      check_eq("rst_sout", sout, 1'b1);
      check_eq("rst_sck_out", sck_out, 1'b1);
      check_eq("rst_sck_oe", sck_oe, 1'b0);
      check_eq("rst_irq", irq, 1'b0);

      // Internal-mode byte: SB=A5, sin=1
      pat = 8'hA5;
      wr_sb(pat);
      check_eq("int_sb_load", sb_q, 8'hA5);
      sin = 1'b1;
      base = irq_cnt;
      wr_sc(8'h81);
      check_eq("int_sc_busy", sc_q, 8'hFF);
      check_eq("int_sck_oe", sck_oe, 1'b1);
      for (int i = 0; i < 8; i++) begin
         do_tick();
         check_eq($sformatf("int_sout_%0d", i), sout, pat[7-i]);
         check_eq($sformatf("int_sck_lo_%0d", i), sck_out, 1'b0);
         cyc(1);
         do_tick();
         check_eq($sformatf("int_sck_hi_%0d", i), sck_out, 1'b1);
         check_eq($sformatf("int_irq_%0d", i), irq, (i == 7) ? 1'b1 : 1'b0);
         cyc(1);
      end
      cyc(3);
      check_eq("int_sb_end", sb_q, 8'hFF);
      check_eq("int_sc_end", sc_q, 8'h7F);
      check_eq("int_irq_once", irq_cnt - base, 1);

      // External-mode byte: sin bits 0,0,1,1,1,1,0,0
      wr_sb(8'h00);
      ebits = 8'b0011_1100;
      base = irq_cnt;
      wr_sc(8'h80);
      check_eq("ext_sc_busy", sc_q, 8'hFE);
      for (int i = 0; i < 8; i++) begin
         sck_in = 1'b0;
         cyc(2);
         check_eq($sformatf("ext_oe_%0d", i), sck_oe, 1'b0);
         sin = ebits[7-i];
         sck_in = 1'b1;
         cyc(2);
         check_eq($sformatf("ext_sck_out_%0d", i), sck_out, 1'b1);
      end
      cyc(2);
      check_eq("ext_sb_end", sb_q, 8'h3C);
      check_eq("ext_irq_once", irq_cnt - base, 1);
      check_eq("ext_sc_end", sc_q, 8'h7E);

      // Abort after 3 rises, then a full restart
      wr_sb(8'h96);
      sin = 1'b0;
      base = irq_cnt;
      wr_sc(8'h81);
      ticks(6);
      check_eq("abt_sb_mid", sb_q, 8'hB0);
      wr_sc(8'h01);
      check_eq("abt_sc", sc_q, 8'h7F);
      check_eq("abt_sck_out", sck_out, 1'b1);
      ticks(4);
      check_eq("abt_idle_sb", sb_q, 8'hB0);
      check_eq("abt_idle_sck", sck_out, 1'b1);
      check_eq("abt_no_irq", irq_cnt - base, 0);
      sin = 1'b1;
      wr_sc(8'h81);
      ticks(15);
      check_eq("abt_rerun_no_irq_15", irq_cnt - base, 0);
      ticks(1);
      cyc(2);
      check_eq("abt_rerun_irq", irq_cnt - base, 1);
      check_eq("abt_rerun_sb", sb_q, 8'hFF);

      // SB write during XFER ignored; tick coincident with SC write discarded
      wr_sb(8'h5A);
      sin = 1'b0;
      base = irq_cnt;
      wr_sc(8'h81);
      ticks(2);
      wr_sb(8'h55);
      check_eq("col_sb_ignored", sb_q, 8'hB4);
      tick = 1'b1;
      wr_sc(8'h81);
      tick = 1'b0;
      check_eq("col_tick_dropped", sck_out, 1'b1);
      cyc(1);
      ticks(13);
      check_eq("col_no_irq_16", irq_cnt - base, 0);
      ticks(1);
      cyc(2);
      check_eq("col_irq_17", irq_cnt - base, 1);
      check_eq("col_sb_end", sb_q, 8'h00);

      // Reset mid-transfer, then sck_in activity in IDLE
      wr_sb(8'hF0);
      sin = 1'b1;
      base = irq_cnt;
      wr_sc(8'h81);
      ticks(10);
      res = 1'b1; tick = 1'b1;
      cyc(1);
      res = 1'b0; tick = 1'b0;
      check_eq("res_sb", sb_q, 8'h00);
      check_eq("res_sc", sc_q, 8'h7E);
      check_eq("res_sout", sout, 1'b1);
      check_eq("res_sck_out", sck_out, 1'b1);
      repeat (4) begin
         sck_in = 1'b0;
         cyc(2);
         sck_in = 1'b1;
         cyc(2);
      end
      ticks(4);
      check_eq("res_idle_sb", sb_q, 8'h00);
      check_eq("res_no_irq", irq_cnt - base, 0);
      wr_sb(8'hC3);
      check_eq("res_sb_load", sb_q, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmg_sio.md
DMG_SIO -- requirements
Module: dmg_sio

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: res  in  1  reset; synchronous and active-high.
REQ-003 SHALL have port: tick  in  1  one-cycle strobe at twice the internal bit rate (16384 Hz), from the divider.
REQ-004 SHALL have ports: sb_we  in  1 (SB write strobe); sc_we  in  1 (SC write strobe); wdata  in  8 (CPU write data).
REQ-005 SHALL have ports: sb_q  out  8 (SB read value); sc_q  out  8 (SC read value).
REQ-006 SHALL have ports: sck_in  in  1 (external serial clock, already synchronised to clk); sin  in  1 (serial data in).
REQ-007 SHALL have ports: sck_out  out  1 (internal serial clock); sck_oe  out  1 (drive enable for sck_out); sout  out  1 (serial data out).
REQ-008 SHALL have port: irq  out  1  serial interrupt request, one-cycle pulse.

Function
REQ-009 SHALL hold SC as two bits: start (bit 7) and clksel (bit 0; 1 = internal clock); sc_q = {start, 6'b111111, clksel}.
REQ-010 SHALL use states IDLE and XFER; a write of start=1 moves IDLE to XFER on the next edge.
REQ-011 SHALL assert sck_oe = clksel in every state; sck_out idles high.
REQ-012 SHALL treat a "fall" as: internal mode, tick while sck_out=1 (sck_out goes 0); external mode, sck_in 1->0 against its registered previous value.
REQ-013 SHALL treat a "rise" as: internal mode, tick while sck_out=0 (sck_out goes 1); external mode, sck_in 0->1 against its registered previous value.
REQ-014 In XFER, on a fall, SHALL update sout <= SB[7] on the same edge.
REQ-015 In XFER, on a rise, SHALL update SB <= {SB[6:0], sin} and increment the 3-bit bit counter.
REQ-016 On the 8th rise (counter 7->0) SHALL clear start, return to IDLE and pulse irq high for exactly one cycle.
REQ-017 SHALL ignore ticks and sck_in edges in IDLE: no shifting, no sck_out toggling, no irq.
REQ-018 Latency: the first fall SHALL occur on the first qualifying tick/edge at least one cycle after the cycle of the start write.
REQ-019 SHALL ignore SB writes during XFER; SB writes in IDLE load wdata on the next edge.
REQ-020 An SC write with start=0 during XFER SHALL abort: go to IDLE, set sck_out=1, clear counter, leave SB as partially shifted, no irq.
REQ-021 An SC write during XFER SHALL update clksel only via abort; start=1 rewrite during XFER SHALL be ignored.
REQ-022 When a register write and a tick/edge occur in the same cycle, the write SHALL take effect and the tick/edge SHALL be discarded.
REQ-023 Internal-mode full byte SHALL take exactly 16 ticks from start to irq.

Reset
REQ-024 While res=1 at a clock edge, SHALL set state IDLE, SB=0x00, start=0, clksel=0, counter=0, sck_out=1, sout=1, irq=0, previous sck_in=1.
REQ-025 res asserted mid-transfer SHALL abandon the transfer with no irq; res SHALL override all simultaneous writes, ticks and edges.

Structure
REQ-026 SHALL place SC bit positions (start=7, clksel=0), the SC unused-bit mask 0x7E and state encodings in a shared dmg_sio_pkg package.
REQ-027 SHALL instantiate one sub-module, dmg_sio_shifter, containing the 8-bit shift register, 3-bit counter and sout register, driven by fall/rise/load strobes.

Verification
REQ-028 Internal mode, SB=0xA5, SC write 0x81, sin=1 -> sout sequence 1,0,1,0,0,1,0,1 on falls; after 16 ticks SB=0xFF, sc_q=0x7F, one irq pulse.
REQ-029 External mode, SB=0x00, SC write 0x80, 8 sck_in pulses with sin bits 0,0,1,1,1,1,0,0 -> SB=0x3C, irq once, sck_oe=0 throughout, sck_out=1.
REQ-030 Internal mode, abort by SC write 0x01 after 3 rises -> state IDLE, no irq, sck_out=1; a later 0x81 start runs a full 8-bit transfer.
REQ-031 SB write 0x55 during XFER and a tick coincident with an SC write -> SB write ignored, tick discarded (transfer takes 17 ticks).
REQ-032 res pulse after 5 rises -> SB=0x00, sc_q=0x7E, sout=1, sck_out=1, no irq; sck_in toggles in IDLE produce no shift.
